// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks an address window of a combinational-read ROM and
// streams each registered word out on a valid/ready port tagged with address and last.
module rom_stream_reader #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W:0]   remaining;
    logic              accept, xfer;

    assign accept   = (state == IDLE) && start && (length != '0);
    assign xfer     = (state == HOLD) && out_valid && out_ready;
    assign rom_addr = addr_reg;
    assign busy     = (state == FETCH) || (state == HOLD);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (length == '0) ? DONE : FETCH;
            FETCH:   state_n = HOLD;
            HOLD:    if (xfer) state_n = out_last ? DONE : FETCH;
            default: state_n = IDLE;
        endcase
    end

    // Address increment wraps naturally at DEPTH through the ADDR_W-bit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg  <= base_addr;
                remaining <= length;
            end
            if (state == FETCH) begin
                out_data  <= rom_data;
                out_addr  <= addr_reg;
                out_last  <= (remaining == (ADDR_W+1)'(1));
                out_valid <= 1'b1;
            end
            if (xfer) begin
                out_valid <= 1'b0;
                remaining <= remaining - 1'b1;
                if (!out_last)
                    addr_reg <= addr_reg + 1'b1;
            end
            if (state == DONE)
                out_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: table-driven scans checked against a beat scoreboard,
// plus hand sequences for reset values and reset mid-scan.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] base_addr = '0;
    logic [2:0] length = '0;
    logic [1:0] rom_addr;
    logic [3:0] rom_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [1:0] out_addr;
    logic       out_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [3:0] rom [4];
    assign rom_data = rom[rom_addr];

    typedef struct {
        logic [1:0] addr;
        logic [3:0] data;
        logic       last;
    } beat_t;
    beat_t sb[$];

    typedef struct {
        int base;
        int len;
        int stall;
        bit poke;
        int exp_done;
    } rec_t;

    always #5 clk = ~clk;

    rom_stream_reader #(.DATA_W(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {rom_addr, out_valid, out_data, out_addr, out_last, busy, done}, 0);
    endtask

    task automatic scan(input rec_t r);
        int stall = r.stall;
        int first_valid = -1;
        int done_cyc = -1;
        beat_t b;
        @(negedge clk);
        start = 1'b1;
        base_addr = 2'(r.base);
        length = 3'(r.len);
        out_ready = (r.stall == 0);
        for (int i = 0; i < r.len; i++) begin
            b.addr = 2'((r.base + i) % 4);
            b.data = rom[(r.base + i) % 4];
            b.last = (i == r.len - 1);
            sb.push_back(b);
        end
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = r.poke && (cyc == 3);
            base_addr = r.poke ? 2'd0 : base_addr;
            length = r.poke ? 3'd1 : length;
            if (out_valid && first_valid < 0) begin
                first_valid = cyc;
                check("busy_in_scan", busy, 1);
            end
            if (out_valid && stall > 0) begin
                stall--;
                out_ready = 1'b0;
                check("stall_data", {out_addr, out_data, out_last},
                      (sb.size() > 0) ? {sb[0].addr, sb[0].data, sb[0].last} : -1);
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    b = sb.pop_front();
                    check("beat_addr", out_addr, b.addr);
                    check("beat_data", out_data, b.data);
                    check("beat_last", out_last, b.last);
                end
            end
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        check("done_cycle", done_cyc, r.exp_done);
        check("first_valid", first_valid, (r.len > 0) ? 1 : -1);
        check("beats_left", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        check("done_one_cycle", {done, busy, out_valid}, 0);
    endtask

    rec_t tbl[7];

    initial begin
        rom[0] = 4'hA; rom[1] = 4'hB; rom[2] = 4'hC; rom[3] = 4'hD;
        tbl[0] = '{0, 4, 0, 1'b0, 8};
        tbl[1] = '{3, 3, 0, 1'b0, 6};
        tbl[2] = '{2, 6, 0, 1'b0, 12};
        tbl[3] = '{1, 2, 5, 1'b0, 9};
        tbl[4] = '{0, 0, 0, 1'b0, 0};
        tbl[5] = '{1, 3, 0, 1'b1, 6};
        tbl[6] = '{2, 7, 2, 1'b0, 16};

        #1;
        check_all_zero("reset_held");
        repeat (2) @(negedge clk);
        check_all_zero("reset_held_clk");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("idle_no_start");

        for (int i = 0; i < 7; i++) scan(tbl[i]);

        @(negedge clk);
        start = 1'b1; base_addr = 2'd0; length = 3'd4; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_valid", {out_valid, busy, out_data}, {1'b1, 1'b1, 4'hA});
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("reset_no_done");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_done", done, 0);
        scan(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
